// File: rtl/subleq_ctrl_if.sv
// Word-memory bus between the SUBLEQ sequencer (master) and a
// single-port memory with a one-cycle registered read (slave).
interface subleq_ctrl_if #(
    parameter int WIDTH = 64
) ();
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;
    logic             mem_re;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/subleq_ctrl.sv
// SUBLEQ control sequencer: fetches A, B, C at pc..pc+2, reads mem[A] and
// mem[B], writes mem[B]-mem[A] to mem[B] and branches to C when the result
// is <= 0. Six cycles per instruction; halts on a negative next pc or when
// the optional instruction watchdog expires.
module subleq_ctrl #(
    parameter int                 WIDTH     = 64,
    parameter logic [WIDTH-1:0]   START_PC  = '0,
    parameter int unsigned        MAX_INSTR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    subleq_ctrl_if.master     mem,
    output logic              busy,
    output logic              halted,
    output logic              timeout,
    output logic [WIDTH-1:0]  pc,
    output logic [31:0]       instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        FETCH_C,
        READ_A,
        READ_B,
        EXEC,
        HALTED
    } state_t;

    localparam logic [31:0]      LIMIT = 32'(MAX_INSTR);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] c_reg, c_next;
    logic [WIDTH-1:0] vala_reg, vala_next;
    logic [31:0]      count_reg, count_next;
    logic             timeout_reg, timeout_next;

    // Datapath for the EXEC cycle: valB arrives on mem_rdata this cycle.
    logic [WIDTH-1:0] diff;
    logic             take;
    logic [WIDTH-1:0] branch_pc;
    logic [31:0]      count_plus;
    logic [31:0]      count_sat;

    assign diff       = mem.mem_rdata - vala_reg;
    assign take       = diff[WIDTH-1] | (diff == '0);
    assign branch_pc  = take ? c_reg : pc_reg + THREE;
    assign count_plus = count_reg + 32'd1;
    assign count_sat  = (count_reg == '1) ? count_reg : count_plus;

    // State and architectural registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            pc_reg      <= START_PC;
            a_reg       <= '0;
            b_reg       <= '0;
            c_reg       <= '0;
            vala_reg    <= '0;
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            c_reg       <= c_next;
            vala_reg    <= vala_next;
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic and memory bus decode.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        c_next        = c_reg;
        vala_next     = vala_reg;
        count_next    = count_reg;
        timeout_next  = timeout_reg;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_we    = 1'b0;
        mem.mem_re    = 1'b0;

        case (state_reg)
            IDLE, HALTED: begin
                if (start) begin
                    pc_next      = START_PC;
                    count_next   = '0;
                    timeout_next = 1'b0;
                    state_next   = FETCH_A;
                end
            end
            FETCH_A: begin
                mem.mem_re   = 1'b1;
                mem.mem_addr = pc_reg;
                state_next   = FETCH_B;
            end
            FETCH_B: begin
                a_next       = mem.mem_rdata;
                mem.mem_re   = 1'b1;
                mem.mem_addr = pc_reg + ONE;
                state_next   = FETCH_C;
            end
            FETCH_C: begin
                b_next       = mem.mem_rdata;
                mem.mem_re   = 1'b1;
                mem.mem_addr = pc_reg + TWO;
                state_next   = READ_A;
            end
            READ_A: begin
                c_next       = mem.mem_rdata;
                mem.mem_re   = 1'b1;
                mem.mem_addr = a_reg;
                state_next   = READ_B;
            end
            READ_B: begin
                vala_next    = mem.mem_rdata;
                mem.mem_re   = 1'b1;
                mem.mem_addr = b_reg;
                state_next   = EXEC;
            end
            EXEC: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = b_reg;
                mem.mem_wdata = diff;
                pc_next       = branch_pc;
                count_next    = count_sat;
                // A negative target halts without flagging the watchdog,
                // even when the limit is reached on the same instruction.
                if (branch_pc[WIDTH-1]) begin
                    state_next = HALTED;
                end else if ((LIMIT != 32'd0) && (count_plus == LIMIT)) begin
                    state_next   = HALTED;
                    timeout_next = 1'b1;
                end else begin
                    state_next = FETCH_A;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy        = (state_reg != IDLE) && (state_reg != HALTED);
    assign halted      = (state_reg == HALTED);
    assign timeout     = timeout_reg;
    assign pc          = pc_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_subleq_ctrl.sv
// Directed bench for subleq_ctrl: small programs are poked into a 256-word
// registered-read memory model and results checked against hand-computed
// values. The instance runs with a watchdog limit of 4 instructions.
module tb_subleq_ctrl;

    localparam int          W    = 64;
    localparam logic [63:0] ONES = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        halted;
    logic        timeout;
    logic [63:0] pc;
    logic [31:0] instr_count;

    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [63:0] ld_data;
    logic [63:0] ram [0:255];

    int checks = 0;
    int errors = 0;

    // Observations from the most recent run
    int          busy_cycles;
    int          we_cycle;
    logic [63:0] we_addr;
    logic [63:0] we_data;
    logic [63:0] pc_at7;
    logic        timeout_at1;

    subleq_ctrl_if #(.WIDTH(W)) bus ();

    subleq_ctrl #(
        .WIDTH    (W),
        .START_PC (64'd0),
        .MAX_INSTR(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem        (bus),
        .busy       (busy),
        .halted     (halted),
        .timeout    (timeout),
        .pc         (pc),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, write at the clock edge, loader port.
    always @(posedge clk) begin
        if (ld_we)
            ram[ld_addr] <= ld_data;
        else if (bus.mem_we)
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_re)
            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Read and write enables must be mutually exclusive on every cycle.
    always @(negedge clk) check("re_we_excl", 64'(bus.mem_re & bus.mem_we), 64'd0);

    assert property (@(posedge clk) !(bus.mem_re && bus.mem_we))
        else $error("mem_re and mem_we high together");

    task automatic poke(input logic [7:0] a, input logic [63:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    // Pulse start, then follow the run until HALTED; mid_start_at>0 re-asserts
    // start on that busy cycle to show it is ignored.
    task automatic run(input string name, input int mid_start_at);
        busy_cycles = 0;
        we_cycle    = 0;
        we_addr     = '0;
        we_data     = '0;
        pc_at7      = '0;
        timeout_at1 = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (halted) break;
            if (busy) begin
                busy_cycles++;
                if (busy_cycles == 1) timeout_at1 = timeout;
                if (busy_cycles == 7) pc_at7 = pc;
                if (bus.mem_we) begin
                    we_cycle = busy_cycles;
                    we_addr  = bus.mem_addr;
                    we_data  = bus.mem_wdata;
                end
            end
            start = (busy_cycles == mid_start_at);
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_halt_reached"}, 64'(halted), 64'd1);
        $display("run %s: busy_cycles=%0d instr_count=%0d pc=%0h timeout=%0b",
                 name, busy_cycles, instr_count, pc, timeout);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy",    64'(busy),        64'd0);
        check("rst_halted",  64'(halted),      64'd0);
        check("rst_timeout", 64'(timeout),     64'd0);
        check("rst_pc",      pc,               64'd0);
        check("rst_count",   64'(instr_count), 64'd0);
        check("rst_re",      64'(bus.mem_re),  64'd0);
        check("rst_addr",    bus.mem_addr,     64'd0);
        $display("reset: state checked");

        // Single-instruction halt
        poke(0, 64'd6); poke(1, 64'd7); poke(2, ONES); poke(6, 64'd5); poke(7, 64'd5);
        run("t1", 0);
        check("t1_busy_cycles", 64'(busy_cycles), 64'd6);
        check("t1_we_cycle",    64'(we_cycle),    64'd6);
        check("t1_we_addr",     we_addr,          64'd7);
        check("t1_we_data",     we_data,          64'd0);
        check("t1_mem7",        ram[7],           64'd0);
        check("t1_pc",          pc,               ONES);
        check("t1_count",       64'(instr_count), 64'd1);
        check("t1_timeout",     64'(timeout),     64'd0);

        // Non-branch then halt
        poke(0, 64'd6); poke(1, 64'd7); poke(2, ONES);
        poke(3, 64'd8); poke(4, 64'd8); poke(5, ONES);
        poke(6, 64'd2); poke(7, 64'd5); poke(8, 64'd9);
        run("t2", 0);
        check("t2_busy_cycles", 64'(busy_cycles), 64'd12);
        check("t2_pc_after_1",  pc_at7,           64'd3);
        check("t2_mem7",        ram[7],           64'd3);
        check("t2_mem8",        ram[8],           64'd0);
        check("t2_count",       64'(instr_count), 64'd2);
        check("t2_pc",          pc,               ONES);

        // Signed wrap, with a start pulse while busy
        poke(0, 64'd20); poke(1, 64'd21); poke(2, ONES);
        poke(3, 64'd22); poke(4, 64'd22); poke(5, ONES);
        poke(20, 64'd1); poke(21, 64'h8000_0000_0000_0000); poke(22, 64'd5);
        run("t3", 3);
        check("t3_mem21",       ram[21],          64'h7FFF_FFFF_FFFF_FFFF);
        check("t3_pc_after_1",  pc_at7,           64'd3);
        check("t3_busy_cycles", 64'(busy_cycles), 64'd12);
        check("t3_count",       64'(instr_count), 64'd2);

        // Negative halt on the watchdog's last instruction: no timeout
        for (int k = 0; k < 3; k++) begin
            poke(8'(3 * k), 64'd30); poke(8'(3 * k + 1), 64'd31); poke(8'(3 * k + 2), 64'd0);
        end
        poke(9, 64'd30); poke(10, 64'd30); poke(11, ONES);
        poke(30, 64'd0); poke(31, 64'd7);
        run("t4", 0);
        check("t4_count",   64'(instr_count), 64'd4);
        check("t4_timeout", 64'(timeout),     64'd0);
        check("t4_pc",      pc,               ONES);
        check("t4_busy",    64'(busy_cycles), 64'd24);

        // Watchdog on an infinite self-branch loop
        poke(0, 64'd3); poke(1, 64'd3); poke(2, 64'd0); poke(3, 64'd9);
        run("t5", 0);
        check("t5_timeout", 64'(timeout),     64'd1);
        check("t5_count",   64'(instr_count), 64'd4);
        check("t5_pc",      pc,               64'd0);
        check("t5_busy",    64'(busy_cycles), 64'd24);

        // Restart from HALTED clears timeout
        poke(0, 64'd6); poke(1, 64'd7); poke(2, ONES); poke(6, 64'd5); poke(7, 64'd5);
        run("t6", 0);
        check("t6_timeout_at_start", 64'(timeout_at1), 64'd0);
        check("t6_timeout",          64'(timeout),     64'd0);
        check("t6_count",            64'(instr_count), 64'd1);
        check("t6_mem7",             ram[7],           64'd0);

        // Reset during READ_A drops the instruction
        poke(7, 64'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t7_read_a_addr", bus.mem_addr, 64'd6);
        rst = 1'b1;
        @(negedge clk);
        check("t7_busy",   64'(busy),        64'd0);
        check("t7_halted", 64'(halted),      64'd0);
        check("t7_we",     64'(bus.mem_we),  64'd0);
        check("t7_re",     64'(bus.mem_re),  64'd0);
        check("t7_pc",     pc,               64'd0);
        check("t7_count",  64'(instr_count), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t7_idle_we", 64'(bus.mem_we), 64'd0);
        end
        check("t7_mem7_kept", ram[7], 64'd5);
        $display("reset mid-instruction: pc=%0h busy=%0b", pc, busy);
        run("t7b", 0);
        check("t7b_count", 64'(instr_count), 64'd1);
        check("t7b_mem7",  ram[7],           64'd0);
        check("t7b_pc",    pc,               ONES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subleq_ctrl.md
Name: subleq_ctrl

Overview:
- Control sequencer for the SUBLEQ CPU. Drives the single-port word memory, which has a 1-cycle registered read.
- Per instruction: fetches operands A, B and C at PC, PC+1 and PC+2. Reads mem[A] and mem[B], then writes mem[B] - mem[A] back to mem[B].
- Next PC is C if the result is <= 0 (signed), otherwise PC+3.
- Halts on a negative next PC or on a watchdog instruction limit.

Parameters:
- WIDTH, 64: data/address word width.
- START_PC, 0: PC loaded on reset and on each accepted start.
- MAX_INSTR, 0: watchdog instruction limit; 0 disables the watchdog.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin execution from START_PC; sampled only in IDLE or HALTED
- mem_addr  output  WIDTH  memory word address
- mem_wdata  output  WIDTH  memory write data
- mem_we  output  1  memory write enable
- mem_re  output  1  memory read enable
- mem_rdata  input  WIDTH  memory data_out, valid the cycle after mem_re
- busy  output  1  high in any execute state
- halted  output  1  high in HALTED
- timeout  output  1  halt was caused by the watchdog
- pc  output  WIDTH  current program counter
- instr_count  output  32  instructions completed since the last start

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, pc=START_PC, instr_count=0; timeout, busy, halted = 0.
  - Operand registers A/B/C and valA/valB cleared.
  - Overrides every other input, including mid-instruction. A pending write is dropped: mem_we is 0 in the cycle after the reset edge.
- mem_* outputs:
  - Combinational decode of state and registers.
  - All zero in IDLE and HALTED.
  - mem_re and mem_we are never high together.
- States, one cycle each, 6 cycles per instruction:
  - IDLE: start=1 -> pc=START_PC, instr_count=0, timeout=0, go to FETCH_A.
  - FETCH_A: re=1, addr=pc.
  - FETCH_B: latch A=mem_rdata; re=1, addr=pc+1.
  - FETCH_C: latch B=mem_rdata; re=1, addr=pc+2.
  - READ_A: latch C=mem_rdata; re=1, addr=A.
  - READ_B: latch valA=mem_rdata; re=1, addr=B.
  - EXEC (valB=mem_rdata used combinationally):
    - diff = valB - valA, modulo 2^WIDTH.
    - we=1, addr=B, wdata=diff.
    - next = C if diff[WIDTH-1]==1 or diff==0, else pc+3.
    - pc<=next; instr_count<=instr_count+1 (saturating at all-ones).
    - If next[WIDTH-1]==1: go to HALTED.
    - Else if MAX_INSTR!=0 and instr_count+1 == MAX_INSTR: go to HALTED with timeout=1.
    - Else go to FETCH_A.
  - HALTED: holds pc, instr_count and timeout. start=1 -> restart exactly as from IDLE.
- start is ignored while busy.
- pc+1, pc+2 and pc+3 wrap modulo 2^WIDTH.
- Address truncation to the memory depth is the memory's responsibility; the controller drives full-width addresses.
- A==B is legal: diff=0, branch taken.
- Self-modifying code:
  - The EXEC write commits at the EXEC edge.
  - The following FETCH_A read sees the updated value. No forwarding is needed.
- The negative-halt check takes priority over the watchdog when both occur in the same EXEC cycle; timeout stays 0.

Test Plan:
- Single-instruction halt. Setup: mem[0]=6, mem[1]=7, mem[2]=all-ones, mem[6]=5, mem[7]=5; pulse start. Required: write mem[7]=0 in the 6th busy cycle; halted=1 next cycle; pc=all-ones; instr_count=1; timeout=0.
- Non-branch then halt. Setup: mem[0..5]={6,7,-1,8,8,-1}, mem[6]=2, mem[7]=5, mem[8]=9. Required: mem[7]=3 and pc=3 after instr 1; mem[8]=0 and halt after instr 2; busy for exactly 12 cycles; instr_count=2.
- Signed wrap. Setup: valB=0x8000_0000_0000_0000, valA=1. Required: diff=0x7FFF_FFFF_FFFF_FFFF, treated as positive, next pc=pc+3.
- Watchdog. Setup: MAX_INSTR=4, mem[0..2]={3,3,0} (infinite self-branch loop). Required: halted=1, timeout=1, instr_count=4, pc=0.
- Reset mid-instruction. Stimulus: rst pulsed during READ_A. Required: next cycle state IDLE, busy=0, mem_we never pulses; a later start re-executes from START_PC with instr_count=0.
- Protocol checks:
  - Assertion that mem_re&mem_we is never 1.
  - start pulsed while busy has no effect.
  - start in HALTED restarts execution and clears timeout.
